// File: rtl/matmul_sched_if.sv
// Bundle of job, J-memory, MatMul and result signals around the MatMul job sequencer.
// The master modport is the sequencer side; slave is the surrounding environment.
interface matmul_sched_if #(
  parameter int VECTOR_SIZE  = 256,
  parameter int ADDR_WIDTH   = 6,
  parameter int ENERGY_WIDTH = 21
);
  logic                           job_valid;
  logic                           job_ready;
  logic [VECTOR_SIZE-1:0]         job_sigma;
  logic signed [ENERGY_WIDTH-1:0] job_energy_prev;

  logic                           mem_req;
  logic [ADDR_WIDTH-1:0]          mem_addr;
  logic                           mem_gnt;

  logic                           mm_start;
  logic [VECTOR_SIZE-1:0]         mm_sigma;
  logic signed [ENERGY_WIDTH-1:0] mm_energy_prev;
  logic                           mm_chunk_valid;
  logic [ADDR_WIDTH-1:0]          mm_chunk_idx;
  logic                           mm_last;
  logic signed [ENERGY_WIDTH-1:0] mm_energy;
  logic                           mm_energy_valid;

  logic                           res_valid;
  logic                           res_ready;
  logic signed [ENERGY_WIDTH-1:0] res_energy;
  logic                           res_accept;
  logic                           res_timeout;
  logic                           busy;

  modport master (
    input  job_valid, job_sigma, job_energy_prev, mem_gnt, mm_energy, mm_energy_valid, res_ready,
    output job_ready, mem_req, mem_addr, mm_start, mm_sigma, mm_energy_prev, mm_chunk_valid,
           mm_chunk_idx, mm_last, res_valid, res_energy, res_accept, res_timeout, busy
  );

  modport slave (
    output job_valid, job_sigma, job_energy_prev, mem_gnt, mm_energy, mm_energy_valid, res_ready,
    input  job_ready, mem_req, mem_addr, mm_start, mm_sigma, mm_energy_prev, mm_chunk_valid,
           mm_chunk_idx, mm_last, res_valid, res_energy, res_accept, res_timeout, busy
  );
endinterface

// File: rtl/matmul_sched.sv
// Job sequencer for the Ising energy MatMul: latches a job, streams all J chunks, returns energy + accept.
// Define MATMUL_SCHED_WDT_EN to add a WAIT_E watchdog that ends a job after WDT_CYCLES silent cycles.
module matmul_sched #(
  parameter int VECTOR_SIZE     = 256,
  parameter int J_COLS_PER_READ = 4,
  parameter int NUM_J_CHUNKS    = VECTOR_SIZE / J_COLS_PER_READ,
  parameter int ADDR_WIDTH      = $clog2(NUM_J_CHUNKS),
  parameter int MEM_LATENCY     = 2,
  parameter int ENERGY_WIDTH    = 21,
  parameter int WDT_CYCLES      = 1024
) (
  input  logic           clk,
  input  logic           rst,
  matmul_sched_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST_CHUNK = ADDR_WIDTH'(NUM_J_CHUNKS - 1);

  if (MEM_LATENCY < 1 || WDT_CYCLES < 1) begin : g_param_check
    $error("matmul_sched: MEM_LATENCY and WDT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, START, FETCH, DRAIN, WAIT_E, RESULT} state_t;

  state_t                                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]                  cnt_q, cnt_d;
  logic [MEM_LATENCY-1:0]                 vld_q, vld_d;
  logic [MEM_LATENCY-1:0][ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [VECTOR_SIZE-1:0]                 sigma_q, sigma_d;
  logic signed [ENERGY_WIDTH-1:0]         eprev_q, eprev_d;
  logic signed [ENERGY_WIDTH-1:0]         res_e_q, res_e_d;
  logic                                   acc_q, acc_d;
`ifdef MATMUL_SCHED_WDT_EN
  localparam int               WDT_W    = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
  logic [WDT_W-1:0]                       wdt_q, wdt_d;
  logic                                   to_q, to_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sigma_d = sigma_q;
    eprev_d = eprev_q;
    res_e_d = res_e_q;
    acc_d   = acc_q;
`ifdef MATMUL_SCHED_WDT_EN
    wdt_d   = '0;
    to_d    = to_q;
`endif
    // In-flight tracker: slot 0 takes this cycle's grant, the top slot is what memory returns now
    vld_d[0] = (state_q == FETCH) && bus.mem_gnt;
    idx_d[0] = cnt_q;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end

    case (state_q)
      IDLE: begin
        if (bus.job_valid) begin
          sigma_d = bus.job_sigma;
          eprev_d = bus.job_energy_prev;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = FETCH;
      end
      FETCH: begin
        if (bus.mem_gnt) begin
          if (cnt_q == LAST_CHUNK) begin
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        // Leave once the last returning chunk has been presented
        if (vld_d == '0) state_d = WAIT_E;
      end
      WAIT_E: begin
        if (bus.mm_energy_valid) begin
          res_e_d = bus.mm_energy;
          acc_d   = bus.mm_energy < eprev_q;
          state_d = RESULT;
`ifdef MATMUL_SCHED_WDT_EN
          to_d    = 1'b0;
        end else if (wdt_q == WDT_LAST) begin
          res_e_d = '0;
          acc_d   = 1'b0;
          to_d    = 1'b1;
          state_d = RESULT;
        end else begin
          wdt_d   = wdt_q + 1'b1;
`endif
        end
      end
      RESULT: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vld_q   <= '0;
      idx_q   <= '0;
      sigma_q <= '0;
      eprev_q <= '0;
      res_e_q <= '0;
      acc_q   <= 1'b0;
`ifdef MATMUL_SCHED_WDT_EN
      wdt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      sigma_q <= sigma_d;
      eprev_q <= eprev_d;
      res_e_q <= res_e_d;
      acc_q   <= acc_d;
`ifdef MATMUL_SCHED_WDT_EN
      wdt_q   <= wdt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign bus.job_ready      = (state_q == IDLE);
  assign bus.busy           = (state_q != IDLE);
  assign bus.mm_start       = (state_q == START);
  assign bus.mem_req        = (state_q == FETCH);
  assign bus.mem_addr       = cnt_q;
  assign bus.mm_sigma       = sigma_q;
  assign bus.mm_energy_prev = eprev_q;
  assign bus.mm_chunk_valid = vld_q[MEM_LATENCY-1];
  assign bus.mm_chunk_idx   = idx_q[MEM_LATENCY-1];
  assign bus.mm_last        = vld_q[MEM_LATENCY-1] && (idx_q[MEM_LATENCY-1] == LAST_CHUNK);
  assign bus.res_valid      = (state_q == RESULT);
  assign bus.res_energy     = res_e_q;
  assign bus.res_accept     = acc_q;
`ifdef MATMUL_SCHED_WDT_EN
  assign bus.res_timeout    = to_q;
`else
  assign bus.res_timeout    = 1'b0;
`endif
endmodule

// File: tb/tb_matmul_sched.sv
// Self-checking bench for matmul_sched: randomized jobs against a cycle-timed reference of the job protocol.
module tb_matmul_sched;
  localparam int VS  = 256;
  localparam int NCH = 64;
  localparam int AW  = 6;
  localparam int L   = 2;
  localparam int EW  = 21;
`ifdef MATMUL_SCHED_WDT_EN
  localparam int WDT = 16;
`else
  localparam int WDT = 1024;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matmul_sched_if #(.VECTOR_SIZE(VS), .ADDR_WIDTH(AW), .ENERGY_WIDTH(EW)) bus ();

  matmul_sched #(
    .VECTOR_SIZE(VS), .J_COLS_PER_READ(4), .MEM_LATENCY(L), .ENERGY_WIDTH(EW), .WDT_CYCLES(WDT)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Observations of the most recent job
  int hs_cyc, start_cyc, start_cnt, last_cnt, last_cyc, res_cyc, res_len;
  int g_cyc[$], g_addr[$], c_cyc[$], c_idx[$];
  logic signed [EW-1:0] r_e;
  logic r_acc, r_to, ready_after, valid_after, rst_ready, rst_busy;
  int unstable, ready_in_res, addr_moved, sig_err, busy_err, post_rst_vld;
  bit timed_out;

  function automatic logic [VS-1:0] rand_sigma();
    logic [VS-1:0] s;
    for (int i = 0; i < VS / 32; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  function automatic logic signed [EW-1:0] rand_energy();
    logic [31:0] t;
    t = $urandom;
    return t[EW-1:0];
  endfunction

  // Drives one job as annealer, J memory and MatMul. Called and returns on a falling edge.
  task automatic do_job(input logic [VS-1:0] sig, input logic signed [EW-1:0] prev,
                        input logic signed [EW-1:0] e, input int gnt_pct, input int e_delay,
                        input int res_delay, input bit no_answer, input int abort_at, input bit reoffer);
    int n = 0, e_due = -1, res_seen = 0, abort_n = 0, stall_addr = 0;
    bit taken = 0, ack = 0, done = 0, aborted = 0, stall_pending = 0;
    logic [31:0] junk;
    g_cyc.delete(); g_addr.delete(); c_cyc.delete(); c_idx.delete();
    start_cnt = 0; last_cnt = 0; last_cyc = -100; res_cyc = -100; res_len = 0; hs_cyc = -100;
    start_cyc = -100; unstable = 0; ready_in_res = 0; addr_moved = 0; sig_err = 0; busy_err = 0;
    post_rst_vld = 0; timed_out = 0; ready_after = 0; valid_after = 1; rst_ready = 0; rst_busy = 1;
    r_e = 'x; r_acc = 1'bx; r_to = 1'bx;
    bus.job_sigma = sig; bus.job_energy_prev = prev;
    while (!done && n < 3000) begin
      if (aborted) begin
        if (abort_n == 0) begin
          rst_ready = bus.job_ready; rst_busy = bus.busy; rst = 1'b0;
        end else if (bus.mm_chunk_valid) post_rst_vld++;
        abort_n++;
        if (abort_n > L + 3) done = 1;
      end else if (ack) begin
        ready_after = bus.job_ready; valid_after = bus.res_valid;
        bus.res_ready = 1'b0; bus.job_valid = 1'b0; done = 1;
      end else begin
        if (taken) begin
          if (bus.mm_start) begin start_cnt++; start_cyc = cyc; end
          if (!bus.busy) busy_err++;
          if (bus.mm_sigma !== sig || bus.mm_energy_prev !== prev) sig_err++;
        end
        if (bus.mm_chunk_valid) begin
          c_cyc.push_back(cyc); c_idx.push_back(int'(bus.mm_chunk_idx));
        end
        if (bus.mm_last) begin
          last_cnt++; last_cyc = cyc;
          if (!no_answer) e_due = cyc + 1 + e_delay;
        end
        if (stall_pending && bus.mem_req && int'(bus.mem_addr) != stall_addr) addr_moved++;
        if (bus.res_valid) begin
          if (res_seen == 0) begin
            res_cyc = cyc; r_e = bus.res_energy; r_acc = bus.res_accept; r_to = bus.res_timeout;
          end else if (bus.res_energy !== r_e || bus.res_accept !== r_acc || bus.res_timeout !== r_to)
            unstable++;
          if (bus.job_ready) ready_in_res++;
          res_seen++;
        end
        // Inputs for the rising edge that closes this cycle
        if (!taken) begin
          bus.job_valid = 1'b1;
          if (bus.job_ready) begin taken = 1; hs_cyc = cyc; end
        end else bus.job_valid = reoffer && (res_seen > 0);
        junk = $urandom;
        bus.mm_energy_valid = 1'b0; bus.mm_energy = junk[EW-1:0];
        if (taken && cyc == hs_cyc + 3) bus.mm_energy_valid = 1'b1;
        if (cyc == e_due) begin bus.mm_energy_valid = 1'b1; bus.mm_energy = e; end
        stall_pending = 0;
        bus.mem_gnt = ($urandom_range(0, 99) < gnt_pct);
        if (bus.mem_req) begin
          if (bus.mem_gnt) begin g_cyc.push_back(cyc); g_addr.push_back(int'(bus.mem_addr)); end
          else begin stall_pending = 1; stall_addr = int'(bus.mem_addr); end
          if (abort_at >= 0 && int'(bus.mem_addr) == abort_at) begin
            rst = 1'b1; aborted = 1; bus.job_valid = 1'b0;
          end
        end
        if (res_seen > res_delay) begin bus.res_ready = 1'b1; ack = 1; res_len = res_seen; end
      end
      if (!done) begin @(negedge clk); n++; end
    end
    bus.job_valid = 1'b0; bus.mem_gnt = 1'b0; bus.mm_energy_valid = 1'b0; bus.res_ready = 1'b0;
    if (!done) begin
      timed_out = 1;
      rst = 1'b1; @(negedge clk); @(negedge clk); rst = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.job_ready !== 1'b1) begin
      errors++; $display("FAIL reset_job_ready: got %b want 1", bus.job_ready);
    end
    checks++;
    if ({bus.busy, bus.mem_req, bus.mm_start, bus.mm_chunk_valid, bus.mm_last, bus.res_valid,
         bus.res_accept, bus.res_timeout} !== 8'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 00000000", {bus.busy, bus.mem_req, bus.mm_start,
        bus.mm_chunk_valid, bus.mm_last, bus.res_valid, bus.res_accept, bus.res_timeout});
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.mm_chunk_idx !== '0 || bus.res_energy !== '0 ||
        bus.mm_energy_prev !== '0 || bus.mm_sigma !== '0) begin
      errors++; $display("FAIL reset_data: addr %0d idx %0d res %0d prev %0d, want all 0",
        bus.mem_addr, bus.mm_chunk_idx, bus.res_energy, bus.mm_energy_prev);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int bad = 0;
    do_job('1, 21'sh0FFFFF, 21'sd65536, 100, 0, 0, 0, -1, 0);
    checks++;
    if (timed_out) begin errors++; $display("FAIL basic_timeout: got timeout want completion"); end
    checks++;
    if (start_cnt != 1 || start_cyc != hs_cyc + 1) begin
      errors++; $display("FAIL basic_start: got %0d pulses at +%0d want 1 at +1", start_cnt, start_cyc - hs_cyc);
    end
    checks++;
    if (c_idx.size() != NCH) begin errors++; $display("FAIL basic_chunk_count: got %0d want %0d", c_idx.size(), NCH); end
    for (int i = 0; i < c_idx.size(); i++)
      if (c_idx[i] != i || c_cyc[i] != hs_cyc + 2 + L + i) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL basic_chunk_timing: got %0d misplaced chunks want 0", bad); end
    checks++;
    if (last_cnt != 1 || last_cyc != hs_cyc + 2 + L + NCH - 1) begin
      errors++; $display("FAIL basic_last: got %0d at +%0d want 1 at +%0d", last_cnt, last_cyc - hs_cyc, 2 + L + NCH - 1);
    end
    checks++;
    if (r_e !== 21'sd65536 || r_acc !== 1'b1 || r_to !== 1'b0) begin
      errors++; $display("FAIL basic_result: got e=%0d acc=%b to=%b want e=65536 acc=1 to=0", r_e, r_acc, r_to);
    end
    checks++;
    if (ready_after !== 1'b1 || valid_after !== 1'b0 || sig_err != 0 || busy_err != 0) begin
      errors++; $display("FAIL basic_status: got ready_after=%b valid_after=%b sig_err=%0d busy_err=%0d want 1 0 0 0",
        ready_after, valid_after, sig_err, busy_err);
    end
  endtask

  task automatic test_compare();
    logic signed [EW-1:0] prevs [4];
    logic signed [EW-1:0] es [4];
    logic exp_acc;
    prevs = '{21'sd100, 21'sd0, -21'sd1, 21'sd0};
    es    = '{21'sd0, 21'sd0, 21'sd0, -21'sd1048576};
    for (int k = 0; k < 4; k++) begin
      do_job({128{2'b10}}, prevs[k], es[k], 100, $urandom_range(0, 3), 0, 0, -1, 0);
      exp_acc = (k == 0 || k == 3);
      checks++;
      if (timed_out || r_e !== es[k] || r_acc !== exp_acc) begin
        errors++; $display("FAIL compare_%0d: got e=%0d acc=%b to=%0d want e=%0d acc=%b",
          k, r_e, r_acc, timed_out, es[k], exp_acc);
      end
    end
  endtask

  task automatic test_random_gnt();
    logic signed [EW-1:0] p, e;
    int bad;
    for (int k = 0; k < 3; k++) begin
      p = rand_energy(); e = (k == 1) ? p : rand_energy();
      do_job(rand_sigma(), p, e, 50, $urandom_range(0, 3), $urandom_range(0, 2), 0, -1, 0);
      checks++;
      if (timed_out || g_addr.size() != NCH || c_idx.size() != NCH) begin
        errors++; $display("FAIL gnt_counts_%0d: got grants=%0d chunks=%0d timeout=%0d want %0d %0d 0",
          k, g_addr.size(), c_idx.size(), timed_out, NCH, NCH);
      end
      bad = 0;
      for (int i = 0; i < c_idx.size() && i < g_cyc.size(); i++)
        if (g_addr[i] != i || c_idx[i] != i || c_cyc[i] != g_cyc[i] + L) bad++;
      checks++;
      if (bad != 0 || addr_moved != 0) begin
        errors++; $display("FAIL gnt_order_%0d: got %0d order errs, %0d addr moves want 0 0", k, bad, addr_moved);
      end
      checks++;
      if (r_e !== e || r_acc !== (e < p) || r_to !== 1'b0) begin
        errors++; $display("FAIL gnt_result_%0d: got e=%0d acc=%b want e=%0d acc=%b", k, r_e, r_acc, e, e < p);
      end
    end
  endtask

  task automatic test_res_stall();
    logic signed [EW-1:0] p, e;
    p = rand_energy(); e = rand_energy();
    do_job(rand_sigma(), p, e, 100, 1, 10, 0, -1, 1);
    checks++;
    if (timed_out || res_len != 11 || unstable != 0) begin
      errors++; $display("FAIL stall_hold: got len=%0d unstable=%0d to=%0d want 11 0 0", res_len, unstable, timed_out);
    end
    checks++;
    if (ready_in_res != 0 || ready_after !== 1'b1 || valid_after !== 1'b0) begin
      errors++; $display("FAIL stall_ready: got in_result=%0d after=%b valid_after=%b want 0 1 0",
        ready_in_res, ready_after, valid_after);
    end
    checks++;
    if (r_e !== e || r_acc !== (e < p)) begin
      errors++; $display("FAIL stall_result: got e=%0d acc=%b want e=%0d acc=%b", r_e, r_acc, e, e < p);
    end
  endtask

  task automatic test_abort();
    logic signed [EW-1:0] p, e;
    do_job(rand_sigma(), rand_energy(), rand_energy(), 100, 0, 0, 0, 20, 0);
    checks++;
    if (rst_ready !== 1'b1 || rst_busy !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got ready=%b busy=%b want 1 0", rst_ready, rst_busy);
    end
    checks++;
    if (post_rst_vld != 0 || c_idx.size() != 19) begin
      errors++; $display("FAIL abort_inflight: got late=%0d before=%0d want 0 19", post_rst_vld, c_idx.size());
    end
    p = rand_energy(); e = rand_energy();
    do_job(rand_sigma(), p, e, 100, 2, 0, 0, -1, 0);
    checks++;
    if (timed_out || c_idx.size() != NCH || r_e !== e || r_acc !== (e < p)) begin
      errors++; $display("FAIL abort_followup: got chunks=%0d e=%0d acc=%b want %0d e=%0d acc=%b",
        c_idx.size(), r_e, r_acc, NCH, e, e < p);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [EW-1:0] p, e;
    for (int k = 0; k < 4; k++) begin
      p = rand_energy(); e = rand_energy();
      do_job(rand_sigma(), p, e, $urandom_range(30, 100), $urandom_range(0, 3), 0, 0, -1, 0);
      checks++;
      if (timed_out || c_idx.size() != NCH || last_cnt != 1 || r_e !== e || r_acc !== (e < p) || r_to !== 1'b0) begin
        errors++; $display("FAIL b2b_%0d: got chunks=%0d last=%0d e=%0d acc=%b want %0d 1 e=%0d acc=%b",
          k, c_idx.size(), last_cnt, r_e, r_acc, NCH, e, e < p);
      end
    end
  endtask

`ifdef MATMUL_SCHED_WDT_EN
  task automatic test_wdt();
    do_job(rand_sigma(), 21'sd500, 21'sd0, 100, 0, 0, 1, -1, 0);
    checks++;
    if (timed_out || res_cyc != last_cyc + 1 + WDT) begin
      errors++; $display("FAIL wdt_timing: got result at +%0d after wait entry want +%0d", res_cyc - last_cyc - 1, WDT);
    end
    checks++;
    if (r_to !== 1'b1 || r_acc !== 1'b0 || r_e !== '0) begin
      errors++; $display("FAIL wdt_result: got to=%b acc=%b e=%0d want 1 0 0", r_to, r_acc, r_e);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.job_valid = 1'b0; bus.job_sigma = '0; bus.job_energy_prev = '0; bus.mem_gnt = 1'b0;
    bus.mm_energy = '0; bus.mm_energy_valid = 1'b0; bus.res_ready = 1'b0;
    test_reset();
    test_basic();
    test_compare();
    test_random_gnt();
    test_res_stall();
    test_abort();
    test_back_to_back();
`ifdef MATMUL_SCHED_WDT_EN
    test_wdt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
